lm_sm_sequencer: RTL and testbench
==================================

# lm_sm_sequencer

Multi-cycle sequencer for LM/SM (load/store multiple) in the 5-stage pipeline. Sits between decode and register-read. Expands one LM/SM with an 8-bit register mask into one single-register micro-op per set mask bit, and holds fetch/decode while the expansion runs. The regA/regB/regC fields it emits feed the Ex-stage forwarding logic unchanged, so forwarding for LM/SM operates per micro-op.

## Interface
Parameters:
- OP_LM, 4'b0110, LM opcode (compared against op_in[5:2])
- OP_SM, 4'b0111, SM opcode (compared against op_in[5:2])

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE
- valid_in  input  1  decode-stage instruction valid
- op_in  input  6  decode-stage op field; bits [5:2] are the major opcode
- ra_in  input  3  base register (regA) of the decode instruction
- imm8_in  input  8  register mask; bit i selects Ri
- stall_in  input  1  downstream hold (load-use stall); freezes sequencer
- flush  input  1  synchronous squash (branch/JAL redirect)
- busy  output  1  sequencer in SEQ
- stall_fetch  output  1  hold PC and IF/ID
- uop_valid  output  1  micro-op present this cycle
- uop_store  output  1  1 = SM micro-op, 0 = LM micro-op
- uop_reg  output  3  data register for this micro-op
- uop_base  output  3  latched base register
- uop_offset  output  3  address offset from base (0..7)
- uop_first  output  1  first micro-op of the instruction
- uop_last  output  1  last micro-op of the instruction

## Operation
- States: IDLE, SEQ. Internal registers: mask_r[7:0], base_r[2:0], store_r, offset_r[2:0].
- accept = IDLE & valid_in & (op_in[5:2]==OP_LM | op_in[5:2]==OP_SM) & imm8_in!=0 & ~stall_in & ~flush.
- On accept: mask_r<=imm8_in, base_r<=ra_in, store_r<=op_in[2], offset_r<=0, state<=SEQ.
- LM/SM with imm8_in==0: not accepted; no micro-op, no stall. The instruction passes through as a NOP.
- In SEQ, uop_reg = index of the lowest set bit of mask_r; uop_offset=offset_r; uop_first=(offset_r==0); uop_last=(mask_r has exactly one bit set).
- SEQ & ~stall_in & ~flush: clear the lowest set bit of mask_r, offset_r<=offset_r+1. If uop_last, go to IDLE.
- SEQ & stall_in: all state holds; outputs are stable.
- flush, any state: go to IDLE and clear mask_r/offset_r. flush has priority over stall_in and accept.
- Outputs are combinational from state: busy=uop_valid=(state==SEQ). uop_store/uop_base come from latched registers. All of them are 0 when IDLE.
- stall_fetch = accept | (SEQ & ~flush & ~(uop_last & ~stall_in)).
- offset_r cannot wrap: at most 8 micro-ops, last offset 7.

## Timing
- Reset values: state IDLE; all registers 0; every output 0.
- Latency: accept in cycle N; first micro-op valid in cycle N+1. With no stalls, a mask of k bits yields micro-ops in N+1..N+k, and the sequencer is IDLE again in N+k+1.
- stall_fetch is high in cycles N..N+k-1 and low in N+k, so the next instruction is presented in N+k and can be accepted in N+k+1 at the earliest.
- Each stall_in cycle extends the sequence by one cycle with identical outputs.
- A valid LM/SM in decode while SEQ is not accepted; it is held by stall_fetch.
- Async reset mid-sequence drops the sequence immediately. There is no partial retire tracking.

## Test plan
- LM, ra_in=3, imm8_in=8'hA5, accept at N: N+1..N+4 give uop_reg 0,2,5,7, uop_offset 0..3, uop_base=3, uop_store=0. uop_first at N+1, uop_last at N+4. stall_fetch high N..N+3, busy low at N+5.
- SM, imm8_in=8'h80: one micro-op at N+1 with uop_reg=7, uop_store=1, first=last=1. stall_fetch high only in cycle N.
- LM, imm8_in=8'h00: no uop_valid, stall_fetch never high, busy stays 0.
- SM, imm8_in=8'hFF, stall_in high for 2 cycles after the 3rd micro-op: uop_reg=2, offset=2 held for 3 cycles total. Full sequence 0..7 completes in 10 cycles, and offset never exceeds 7.
- LM 8'h0F, flush with the 2nd micro-op: IDLE next cycle, outputs 0, stall_fetch low in the flush cycle. A following LM 8'h01 is accepted normally.
- LM 8'hF0, async reset asserted mid-cycle after the 1st micro-op: all outputs 0 immediately. After release, ADD/LW ops in decode never cause accept, and stall_fetch stays 0.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
// Decode-side request and micro-op result bundle for the LM/SM sequencer.
// The master drives decode fields and pipeline controls; the slave returns micro-ops.
interface lm_sm_sequencer_if;
  logic       valid_in;
  logic [5:0] op_in;
  logic [2:0] ra_in;
  logic [7:0] imm8_in;
  logic       stall_in;
  logic       flush;
  logic       busy;
  logic       stall_fetch;
  logic       uop_valid;
  logic       uop_store;
  logic [2:0] uop_reg;
  logic [2:0] uop_base;
  logic [2:0] uop_offset;
  logic       uop_first;
  logic       uop_last;

  modport master (
    output valid_in, op_in, ra_in, imm8_in, stall_in, flush,
    input  busy, stall_fetch, uop_valid, uop_store, uop_reg, uop_base,
           uop_offset, uop_first, uop_last
  );

  modport slave (
    input  valid_in, op_in, ra_in, imm8_in, stall_in, flush,
    output busy, stall_fetch, uop_valid, uop_store, uop_reg, uop_base,
           uop_offset, uop_first, uop_last
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM with an 8-bit register mask into single-register micro-ops,
// lowest register first, holding fetch/decode until the last micro-op issues.
module lm_sm_sequencer #(
  parameter logic [3:0] OP_LM = 4'b0110,
  parameter logic [3:0] OP_SM = 4'b0111
) (
  input logic           clk,
  input logic           reset,
  lm_sm_sequencer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] mask_r, mask_nxt;
  logic [2:0] base_r, base_nxt;
  logic       store_r, store_nxt;
  logic [2:0] offset_r, offset_nxt;

  logic       is_lmsm;
  logic       accept;
  logic       in_seq;
  logic       last;
  logic       unused_op_bits;

  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [7:0] m);
    return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
  endfunction

  // Only the major opcode and its LSB (LM vs SM) matter here.
  assign unused_op_bits = ^bus.op_in[1:0];

  assign is_lmsm = (bus.op_in[5:2] == OP_LM) || (bus.op_in[5:2] == OP_SM);
  assign in_seq  = (state == SEQ);
  assign last    = single_bit(mask_r);
  assign accept  = (state == IDLE) && bus.valid_in && is_lmsm &&
                   (bus.imm8_in != 8'd0) && !bus.stall_in && !bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mask_r   <= 8'd0;
      base_r   <= 3'd0;
      store_r  <= 1'b0;
      offset_r <= 3'd0;
    end else begin
      state    <= state_nxt;
      mask_r   <= mask_nxt;
      base_r   <= base_nxt;
      store_r  <= store_nxt;
      offset_r <= offset_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mask_nxt   = mask_r;
    base_nxt   = base_r;
    store_nxt  = store_r;
    offset_nxt = offset_r;

    // Flush beats both the stall hold and a fresh accept.
    if (bus.flush) begin
      state_nxt  = IDLE;
      mask_nxt   = 8'd0;
      offset_nxt = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt  = SEQ;
            mask_nxt   = bus.imm8_in;
            base_nxt   = bus.ra_in;
            store_nxt  = bus.op_in[2];
            offset_nxt = 3'd0;
          end
        end
        SEQ: begin
          if (!bus.stall_in) begin
            mask_nxt   = mask_r & (mask_r - 8'd1);
            offset_nxt = offset_r + 3'd1;
            if (last) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    bus.busy        = in_seq;
    bus.uop_valid   = in_seq;
    bus.uop_store   = in_seq & store_r;
    bus.uop_reg     = in_seq ? lowest_idx(mask_r) : 3'd0;
    bus.uop_base    = in_seq ? base_r : 3'd0;
    bus.uop_offset  = in_seq ? offset_r : 3'd0;
    bus.uop_first   = in_seq && (offset_r == 3'd0);
    bus.uop_last    = in_seq && last;
    // Fetch is released in the cycle the last micro-op actually issues.
    bus.stall_fetch = accept || (in_seq && !bus.flush && !(last && !bus.stall_in));
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: expected micro-ops are queued at issue
// and popped by a negedge monitor; control outputs are checked per scenario.
module tb_lm_sm_sequencer;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LW  = 4'b0100;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  lm_sm_sequencer_if bus();

  lm_sm_sequencer #(.OP_LM(OP_LM), .OP_SM(OP_SM)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       store;
    logic [2:0] rg;
    logic [2:0] base;
    logic [2:0] off;
    logic       first;
    logic       last;
  } uop_t;

  uop_t sb[$];
  uop_t mon_exp, mon_act;
  int   n_assert = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    if (bus.uop_valid === 1'b1) begin
      n_assert++;
      mon_act = {bus.uop_store, bus.uop_reg, bus.uop_base, bus.uop_offset,
                 bus.uop_first, bus.uop_last};
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL uop_unexpected: got %h, required no micro-op", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL uop_fields: got st=%0b reg=%0d base=%0d off=%0d f=%0b l=%0b, required st=%0b reg=%0d base=%0d off=%0d f=%0b l=%0b",
                   mon_act.store, mon_act.rg, mon_act.base, mon_act.off, mon_act.first, mon_act.last,
                   mon_exp.store, mon_exp.rg, mon_exp.base, mon_exp.off, mon_exp.first, mon_exp.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1);
  end

  function automatic logic [14:0] outs();
    return {bus.busy, bus.stall_fetch, bus.uop_valid, bus.uop_store, bus.uop_reg,
            bus.uop_base, bus.uop_offset, bus.uop_first, bus.uop_last};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in = 1'b0;
    bus.op_in    = 6'd0;
    bus.ra_in    = 3'd0;
    bus.imm8_in  = 8'd0;
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic drive_op(input logic [3:0] opc, input logic [2:0] ra, input logic [7:0] m);
    bus.valid_in = 1'b1;
    bus.op_in    = {opc, 2'b00};
    bus.ra_in    = ra;
    bus.imm8_in  = m;
  endtask

  task automatic push_uop(input logic st, input logic [2:0] rg, input logic [2:0] base,
                          input logic [2:0] off, input logic first, input logic last);
    uop_t u;
    u = {st, rg, base, off, first, last};
    sb.push_back(u);
  endtask

  task automatic push_mask(input logic [7:0] m, input logic [2:0] base, input logic st);
    int total, cnt;
    total = 0;
    cnt   = 0;
    for (int i = 0; i < 8; i++) if (m[i]) total++;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        push_uop(st, 3'(i), base, 3'(cnt), cnt == 0, cnt == total - 1);
        cnt++;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    n_assert++;
    if (outs() !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", outs());
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_assert++;
    if (outs() !== 15'd0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got %h, required 0", outs());
    end
    next_cycle();
  endtask

  task automatic test_lm_basic();
    logic [5:0] exp_sf, exp_busy;
    exp_sf   = 6'b001111;
    exp_busy = 6'b011110;
    push_mask(8'hA5, 3'd3, 1'b0);
    drive_op(OP_LM, 3'd3, 8'hA5);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_assert++;
      if (bus.stall_fetch !== exp_sf[c] || bus.busy !== exp_busy[c]) begin
        n_fail++;
        $display("FAIL lm_a5_ctrl c%0d: got sf=%0b busy=%0b, required sf=%0b busy=%0b",
                 c, bus.stall_fetch, bus.busy, exp_sf[c], exp_busy[c]);
      end
      next_cycle();
      bus.valid_in = 1'b0;
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL lm_a5_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_sm_single();
    logic [2:0] exp_sf, exp_busy;
    exp_sf   = 3'b001;
    exp_busy = 3'b010;
    push_mask(8'h80, 3'd5, 1'b1);
    drive_op(OP_SM, 3'd5, 8'h80);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_assert++;
      if (bus.stall_fetch !== exp_sf[c] || bus.busy !== exp_busy[c]) begin
        n_fail++;
        $display("FAIL sm_80_ctrl c%0d: got sf=%0b busy=%0b, required sf=%0b busy=%0b",
                 c, bus.stall_fetch, bus.busy, exp_sf[c], exp_busy[c]);
      end
      next_cycle();
      bus.valid_in = 1'b0;
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sm_80_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_zero_mask();
    drive_op(OP_LM, 3'd2, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_assert++;
      if ({bus.stall_fetch, bus.busy, bus.uop_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL zero_mask c%0d: got sf/busy/valid=%b, required 000",
                 c, {bus.stall_fetch, bus.busy, bus.uop_valid});
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    int n_valid, done_cyc, max_off;
    n_valid  = 0;
    done_cyc = 0;
    max_off  = 0;
    for (int i = 0; i < 8; i++) begin
      push_uop(1'b1, 3'(i), 3'd1, 3'(i), i == 0, i == 7);
      if (i == 2) begin
        push_uop(1'b1, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0);
        push_uop(1'b1, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0);
      end
    end
    drive_op(OP_SM, 3'd1, 8'hFF);
    @(negedge clk);
    n_assert++;
    if (bus.stall_fetch !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_accept_sf: got %0b, required 1", bus.stall_fetch);
    end
    next_cycle();
    bus.valid_in = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      bus.stall_in = (cyc == 3 || cyc == 4);
      @(negedge clk);
      if (bus.busy !== 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (bus.uop_valid === 1'b1) n_valid++;
      if (int'(bus.uop_offset) > max_off) max_off = int'(bus.uop_offset);
      n_assert++;
      if (bus.stall_fetch !== (cyc < 10)) begin
        n_fail++;
        $display("FAIL stall_sf c%0d: got %0b, required %0b", cyc, bus.stall_fetch, cyc < 10);
      end
      next_cycle();
    end
    next_cycle();
    bus.stall_in = 1'b0;
    n_assert++;
    if (done_cyc != 11 || n_valid != 10 || max_off != 7) begin
      n_fail++;
      $display("FAIL stall_length: got idle_at=%0d uops=%0d max_off=%0d, required 11 10 7",
               done_cyc, n_valid, max_off);
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_flush();
    push_uop(1'b0, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0);
    push_uop(1'b0, 3'd1, 3'd2, 3'd1, 1'b0, 1'b0);
    drive_op(OP_LM, 3'd2, 8'h0F);
    next_cycle();
    bus.valid_in = 1'b0;
    next_cycle();
    bus.flush = 1'b1;
    @(negedge clk);
    n_assert++;
    if (bus.stall_fetch !== 1'b0 || bus.uop_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: got sf=%0b valid=%0b, required sf=0 valid=1",
               bus.stall_fetch, bus.uop_valid);
    end
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    n_assert++;
    if (outs() !== 15'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_idle: got outs=%h pending=%0d, required 0 0", outs(), sb.size());
    end
    next_cycle();
    push_mask(8'h01, 3'd6, 1'b0);
    drive_op(OP_LM, 3'd6, 8'h01);
    @(negedge clk);
    n_assert++;
    if (bus.stall_fetch !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_reaccept: got sf=%0b busy=%0b, required sf=1 busy=0",
               bus.stall_fetch, bus.busy);
    end
    next_cycle();
    bus.valid_in = 1'b0;
    @(negedge clk);
    n_assert++;
    if (bus.stall_fetch !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_reseq: got sf=%0b busy=%0b, required sf=0 busy=1",
               bus.stall_fetch, bus.busy);
    end
    next_cycle();
    next_cycle();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_sf, exp_busy;
    exp_sf   = 6'b001011;
    exp_busy = 6'b010110;
    push_mask(8'h03, 3'd1, 1'b0);
    push_mask(8'h04, 3'd2, 1'b1);
    drive_op(OP_LM, 3'd1, 8'h03);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_assert++;
      if (bus.stall_fetch !== exp_sf[c] || bus.busy !== exp_busy[c]) begin
        n_fail++;
        $display("FAIL b2b_ctrl c%0d: got sf=%0b busy=%0b, required sf=%0b busy=%0b",
                 c, bus.stall_fetch, bus.busy, exp_sf[c], exp_busy[c]);
      end
      next_cycle();
      if (c < 3) drive_op(OP_SM, 3'd2, 8'h04);
      else bus.valid_in = 1'b0;
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] opc_tab[4];
    logic [1:0] ctl_tab[4];
    opc_tab = '{OP_ADD, OP_LW, OP_LM, OP_SM};
    ctl_tab = '{2'b00, 2'b00, 2'b10, 2'b01};
    push_uop(1'b0, 3'd4, 3'd4, 3'd0, 1'b1, 1'b0);
    drive_op(OP_LM, 3'd4, 8'hF0);
    next_cycle();
    bus.valid_in = 1'b0;
    next_cycle();
    #1;
    reset = 1'b1;
    #1;
    n_assert++;
    if (outs() !== 15'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL async_reset: got outs=%h pending=%0d, required 0 0", outs(), sb.size());
    end
    next_cycle();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive_op(opc_tab[t], 3'd7, 8'hFF);
      bus.flush    = ctl_tab[t][1];
      bus.stall_in = ctl_tab[t][0];
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        n_assert++;
        if ({bus.stall_fetch, bus.busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL no_accept t%0d c%0d: got sf/busy=%b, required 00",
                   t, c, {bus.stall_fetch, bus.busy});
        end
        next_cycle();
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_single();
    test_zero_mask();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
